cross_bar_arbiter: RTL

//  Shares one slave port of the req/ack/resp bus among NUM_MASTERS master ports using round-robin arbitration.

---
 rtl/cross_bar_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/cross_bar_arbiter.sv
// cross_bar_arbiter: shares one slave req/ack/resp port among NUM_MASTERS masters with
// round-robin arbitration, one transaction outstanding at a time.
// Optional ack watchdog: define ARB_TIMEOUT_EN to abort a request the slave never accepts.
module cross_bar_arbiter #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned DWIDTH         = 32,
  parameter int unsigned AWIDTH         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS*AWIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS-1:0]        m_cmd,
  input  logic [NUM_MASTERS*DWIDTH-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic [NUM_MASTERS*DWIDTH-1:0] m_rdata,
  output logic [NUM_MASTERS-1:0]        m_resp,
  output logic                          s_req,
  output logic [AWIDTH-1:0]             s_addr,
  output logic                          s_cmd,
  output logic [DWIDTH-1:0]             s_wdata,
  input  logic                          s_ack,
  input  logic [DWIDTH-1:0]             s_rdata,
  input  logic                          s_resp,
  output logic                          timeout
);

  localparam int unsigned GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned CW = GW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] ptr_q, ptr_d;
  logic [GW-1:0] winner;
  logic [CW-1:0] cand;
  logic          found;
  logic          expire;
  logic          abort_q, abort_d;

  // Round-robin search: first requester at or after ptr, wrapping modulo NUM_MASTERS.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = {1'b0, ptr_q} + CW'(i);
      if (cand >= CW'(NUM_MASTERS)) cand = cand - CW'(NUM_MASTERS);
      if (!found && m_req[cand[GW-1:0]]) begin
        found  = 1'b1;
        winner = cand[GW-1:0];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] cnt_q;

  // s_ack in the expiry cycle takes priority over the abort.
  assign expire  = (state_q == REQ) && !s_ack && (cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign timeout = expire;

  // Watchdog: zero outside REQ, counts REQ cycles spent waiting for s_ack.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else if (state_q != REQ) begin
      cnt_q <= '0;
    end else if (!s_ack && !expire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Next-state: IDLE -> REQ on a winner, REQ -> RESP on accept or abort, RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    abort_d = abort_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = winner;
          ptr_d   = (winner == GW'(NUM_MASTERS - 1)) ? '0 : winner + 1'b1;
          abort_d = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (s_ack) begin
          state_d = RESP;
        end else if (expire) begin
          abort_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        abort_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any transaction in flight.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      abort_q <= abort_d;
    end
  end

  // Outputs: live mux of the granted master's fields, responses routed only to the grantee.
  always_comb begin
    s_req   = (state_q == REQ);
    s_addr  = '0;
    s_cmd   = 1'b0;
    s_wdata = '0;
    m_ack   = '0;
    m_resp  = '0;
    m_rdata = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q == GW'(i)) begin
        if (state_q == REQ) begin
          s_addr   = m_addr[i*AWIDTH +: AWIDTH];
          s_cmd    = m_cmd[i];
          s_wdata  = m_wdata[i*DWIDTH +: DWIDTH];
          m_ack[i] = s_ack | expire;
        end
        if (state_q == RESP) begin
          m_resp[i] = abort_q | s_resp;
          if (!abort_q) m_rdata[i*DWIDTH +: DWIDTH] = s_rdata;
        end
      end
    end
  end

endmodule
